irq_pc_sequencer: RTL and testbench
===================================

# irq_pc_sequencer

Next-PC controller for the RISC interrupt core. It owns the PC register's `pc_enable`/`nxt_pc` inputs. It selects between sequential fetch, branch target, interrupt vector and `mret` return address. It arbitrates among level-sensitive interrupt lines, drains the pipeline before vectoring, and holds the saved return PC (`mepc`) and cause (`mcause`).

## Interface
Parameters:
- `RESET_VEC`, 32'h0000_0000: value driven on `o_nxt_pc` while in reset.
- `IRQ_VEC`, 32'h0000_0100: interrupt vector base.
- `NUM_IRQ`, 4: number of interrupt lines (1..16).
- `DRAIN_CYC`, 2: pipeline drain cycles before vectoring (0..7).

Ports:
- `i_clk`, in, 1: clock. One clock domain.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_pc`, in, 32: current PC from the PC register.
- `i_stall`, in, 1: pipeline stall. No PC update while high.
- `i_br_taken`, in, 1: branch/jump resolved taken this cycle.
- `i_br_target`, in, 32: branch target.
- `i_mret`, in, 1: `mret` retiring this cycle.
- `i_mie`, in, 1: global interrupt enable.
- `i_irq`, in, NUM_IRQ: level interrupt requests.
- `o_nxt_pc`, out, 32: next PC to the PC register.
- `o_pc_enable`, out, 1: PC load enable.
- `o_flush`, out, 1: flush younger pipeline stages.
- `o_irq_ack`, out, NUM_IRQ: one-hot, one-cycle acknowledge.
- `o_mepc`, out, 32: saved return PC (registered).
- `o_mcause`, out, 32: saved cause (registered).
- `o_in_isr`, out, 1: handler active.

## Operation
- FSM states: RUN, DRAIN, TRAP, ISR. Reset state is RUN.
- Pending condition: `pend = |i_irq & i_mie`. Winner is the lowest set index.
- **RUN**
  - `o_nxt_pc` = `i_br_taken ? i_br_target : i_pc+4`.
  - `o_pc_enable` = `!i_stall`.
  - If `pend & !i_stall`:
    - Suppress the load (`o_pc_enable`=0).
    - Latch `mepc` = the value RUN would have loaded (the branch target when taken; the branch wins for mepc).
    - Latch winner index `idx` and `mcause` = 32'h8000_0010 + idx.
    - Assert `o_flush` for this cycle.
    - Go to DRAIN, or to TRAP if DRAIN_CYC=0.
  - `i_mret` in RUN is ignored.
- **DRAIN**
  - `o_pc_enable`=0, `o_flush`=1.
  - A counter runs DRAIN_CYC cycles regardless of `i_stall`, then the FSM goes to TRAP.
- **TRAP**
  - `o_nxt_pc` = vector (see Configuration); `o_flush`=1.
  - `o_pc_enable` = `!i_stall`.
  - On the load cycle only: `o_irq_ack[idx]`=1, then go to ISR. While stalled, the FSM stays in TRAP.
- **ISR**
  - Sequencing is the same as RUN, but no interrupt is taken (no nesting). `o_in_isr`=1.
  - On `i_mret & !i_stall`: `o_nxt_pc`=`o_mepc`, `o_pc_enable`=1, `o_flush`=1, go to RUN.
  - `i_mret` has priority over `i_br_taken`.
- `idx` is latched at detection. Deassertion of `i_irq` during DRAIN/TRAP does not cancel the trap.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Outputs `o_nxt_pc`, `o_pc_enable`, `o_flush`, `o_irq_ack`, `o_in_isr` are combinational from state plus inputs.
- `o_mepc` and `o_mcause` are registered.
- While `i_rst`=1:
  - `o_nxt_pc`=RESET_VEC.
  - `o_pc_enable`=0, `o_flush`=0, `o_irq_ack`=0, `o_in_isr`=0.
  - `o_mepc` and `o_mcause` are cleared to 0 at the clock edge.
- Reset asserted mid-trap (DRAIN, TRAP or ISR) returns the FSM to RUN on the next edge and discards the latched `idx`.
- Interrupt latency with no stall, detected in cycle T:
  - DRAIN occupies T+1..T+DRAIN_CYC.
  - TRAP is cycle T+DRAIN_CYC+1.
  - `i_pc` = vector in cycle T+DRAIN_CYC+2.
- The `mret` return takes effect in `i_pc` on the cycle after `mret` is accepted.
- `o_irq_ack` is high for exactly one cycle per trap.

## Configuration
- Macro `IRQ_VECTORED_EN`:
  - Defined: vector = IRQ_VEC + 4·idx.
  - Undefined: vector = IRQ_VEC for all lines.
- `o_mcause` encodes `idx` identically in both builds.

## Test plan
- **Reset:** hold `i_rst`=1 for 3 cycles. Expect `o_nxt_pc`=0, `o_pc_enable`=0, `o_mepc`=0. After release with `i_pc`=0x40, expect `o_nxt_pc`=0x44 and `o_pc_enable`=1.
- **Sequential/branch/stall:** `i_pc`=0x80 with `i_br_taken`=1 and target 0x200 gives `o_nxt_pc`=0x200. `i_stall`=1 gives `o_pc_enable`=0.
- **Interrupt arbitration:** `i_irq`=4'b0110, `i_mie`=1, `i_pc`=0x1000, DRAIN_CYC=2. Expect:
  - `mepc`=0x1004, `mcause`=0x8000_0011.
  - TRAP 3 cycles later with `o_irq_ack`=4'b0010.
  - PC=0x104 with `IRQ_VECTORED_EN`, or 0x100 without.
- **Branch + interrupt same cycle:** branch target 0x300 → `o_mepc`=0x300.
- **Masking and no nesting:** `i_mie`=0 → no trap. In ISR, `i_irq`=4'b0001 → no trap. `mret` → `o_nxt_pc`=`o_mepc`, then RUN.
- **Stall in TRAP and reset mid-drain:**
  - Stall held 2 cycles in TRAP → ack delayed 2 cycles and still a single pulse.
  - `i_rst` during DRAIN → RUN, no ack emitted.

Source files
------------

// File: rtl/irq_pc_sequencer.sv
// Next-PC sequencer: sequential/branch fetch, interrupt drain/vector, mret return.
// Optional IRQ_VECTORED_EN: vector = IRQ_VEC + 4*idx (otherwise a single IRQ_VEC).
module irq_pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h0000_0100,
  parameter int unsigned NUM_IRQ   = 4,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [31:0]        i_pc,
  input  logic               i_stall,
  input  logic               i_br_taken,
  input  logic [31:0]        i_br_target,
  input  logic               i_mret,
  input  logic               i_mie,
  input  logic [NUM_IRQ-1:0] i_irq,
  output logic [31:0]        o_nxt_pc,
  output logic               o_pc_enable,
  output logic               o_flush,
  output logic [NUM_IRQ-1:0] o_irq_ack,
  output logic [31:0]        o_mepc,
  output logic [31:0]        o_mcause,
  output logic               o_in_isr
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_TRAP  = 2'd2;
  localparam logic [1:0] ST_ISR   = 2'd3;

  localparam logic [2:0] DRAIN_LOAD = (DRAIN_CYC == 0) ? 3'd0 : 3'(DRAIN_CYC - 1);

  logic [1:0]  state;
  logic [2:0]  drain_cnt;
  logic [3:0]  idx;
  logic [3:0]  win;
  logic        pend;
  logic        take;
  logic [31:0] seq_pc;
  logic [31:0] vec_pc;

  assign pend   = (|i_irq) & i_mie;
  assign seq_pc = i_br_taken ? i_br_target : i_pc + 32'd4;

`ifdef IRQ_VECTORED_EN
  assign vec_pc = IRQ_VEC + {26'd0, idx, 2'b00};
`else
  assign vec_pc = IRQ_VEC;
`endif

  // Scan high-to-low so the lowest set index is the one left standing.
  always_comb begin
    win = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (i_irq[i-1]) win = 4'(i - 1);
    end
  end

  always_comb begin
    o_nxt_pc    = seq_pc;
    o_pc_enable = 1'b0;
    o_flush     = 1'b0;
    o_irq_ack   = '0;
    o_in_isr    = 1'b0;
    take        = 1'b0;
    if (i_rst) begin
      o_nxt_pc = RESET_VEC;
    end else begin
      case (state)
        ST_RUN: begin
          o_pc_enable = !i_stall;
          if (pend && !i_stall) begin
            o_pc_enable = 1'b0;
            o_flush     = 1'b1;
            take        = 1'b1;
          end
        end
        ST_DRAIN: o_flush = 1'b1;
        ST_TRAP: begin
          o_nxt_pc    = vec_pc;
          o_flush     = 1'b1;
          o_pc_enable = !i_stall;
          if (!i_stall) begin
            for (int unsigned i = 0; i < NUM_IRQ; i++) o_irq_ack[i] = (idx == 4'(i));
          end
        end
        default: begin
          o_in_isr = 1'b1;
          if (i_mret && !i_stall) begin
            o_nxt_pc    = o_mepc;
            o_pc_enable = 1'b1;
            o_flush     = 1'b1;
          end else begin
            o_pc_enable = !i_stall;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      idx       <= '0;
      o_mepc    <= '0;
      o_mcause  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (take) begin
            o_mepc    <= seq_pc;
            o_mcause  <= 32'h8000_0010 + {28'd0, win};
            idx       <= win;
            drain_cnt <= DRAIN_LOAD;
            state     <= (DRAIN_CYC == 0) ? ST_TRAP : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 3'd0) state <= ST_TRAP;
          else drain_cnt <= drain_cnt - 3'd1;
        end
        ST_TRAP: if (!i_stall) state <= ST_ISR;
        default: if (i_mret && !i_stall) state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pc_sequencer.sv
// Directed bench for irq_pc_sequencer; a bench-side PC register closes the nxt_pc loop.
module tb_irq_pc_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_pc;
  logic        i_stall;
  logic        i_br_taken;
  logic [31:0] i_br_target;
  logic        i_mret;
  logic        i_mie;
  logic [3:0]  i_irq;
  logic [31:0] o_nxt_pc;
  logic        o_pc_enable;
  logic        o_flush;
  logic [3:0]  o_irq_ack;
  logic [31:0] o_mepc;
  logic [31:0] o_mcause;
  logic        o_in_isr;

  logic        load_req;
  logic [31:0] load_val;
  int          n_checks = 0;
  int          n_errors = 0;

`ifdef IRQ_VECTORED_EN
  localparam logic [31:0] VEC1 = 32'h0000_0104;
  localparam logic [31:0] VEC2 = 32'h0000_0108;
`else
  localparam logic [31:0] VEC1 = 32'h0000_0100;
  localparam logic [31:0] VEC2 = 32'h0000_0100;
`endif

  irq_pc_sequencer #(
    .RESET_VEC (32'h0000_0000),
    .IRQ_VEC   (32'h0000_0100),
    .NUM_IRQ   (4),
    .DRAIN_CYC (2)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_pc        (i_pc),
    .i_stall     (i_stall),
    .i_br_taken  (i_br_taken),
    .i_br_target (i_br_target),
    .i_mret      (i_mret),
    .i_mie       (i_mie),
    .i_irq       (i_irq),
    .o_nxt_pc    (o_nxt_pc),
    .o_pc_enable (o_pc_enable),
    .o_flush     (o_flush),
    .o_irq_ack   (o_irq_ack),
    .o_mepc      (o_mepc),
    .o_mcause    (o_mcause),
    .o_in_isr    (o_in_isr)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (load_req) i_pc <= load_val;
    else if (o_pc_enable) i_pc <= o_nxt_pc;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] v);
    load_val = v;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_stall = 1'b0; i_br_taken = 1'b0; i_br_target = '0;
    i_mret = 1'b0; i_mie = 1'b0; i_irq = '0; load_req = 1'b1; load_val = 32'h40;
    #1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("rst_nxt_pc", o_nxt_pc, 32'h0);
      check_eq("rst_pc_en", {31'd0, o_pc_enable}, 32'd0);
      check_eq("rst_flush", {31'd0, o_flush}, 32'd0);
      check_eq("rst_ack", {28'd0, o_irq_ack}, 32'd0);
      tick();
      check_eq("rst_mepc", o_mepc, 32'h0);
      check_eq("rst_mcause", o_mcause, 32'h0);
    end
    i_rst = 1'b0; load_req = 1'b0; #1;
    check_eq("post_rst_nxt", o_nxt_pc, 32'h44);
    check_eq("post_rst_en", {31'd0, o_pc_enable}, 32'd1);

    set_pc(32'h80);
    i_br_taken = 1'b1; i_br_target = 32'h200; #1;
    check_eq("branch_nxt", o_nxt_pc, 32'h200);
    check_eq("branch_en", {31'd0, o_pc_enable}, 32'd1);
    i_stall = 1'b1; #1;
    check_eq("stall_en", {31'd0, o_pc_enable}, 32'd0);
    i_stall = 1'b0; i_br_taken = 1'b0;
    set_pc(32'hFFFF_FFFC); #1;
    check_eq("wrap_nxt", o_nxt_pc, 32'h0);

    // Masked interrupt, then unmask: arbitration picks index 1.
    set_pc(32'h1000);
    i_irq = 4'b0110; #1;
    check_eq("masked_flush", {31'd0, o_flush}, 32'd0);
    check_eq("masked_en", {31'd0, o_pc_enable}, 32'd1);
    i_mie = 1'b1; #1;
    check_eq("detect_flush", {31'd0, o_flush}, 32'd1);
    check_eq("detect_en", {31'd0, o_pc_enable}, 32'd0);
    tick();
    i_irq = '0; #1;
    check_eq("arb_mepc", o_mepc, 32'h1004);
    check_eq("arb_mcause", o_mcause, 32'h8000_0011);
    check_eq("drain1_en", {31'd0, o_pc_enable}, 32'd0);
    check_eq("drain1_flush", {31'd0, o_flush}, 32'd1);
    tick();
    check_eq("drain2_ack", {28'd0, o_irq_ack}, 32'd0);
    check_eq("drain2_en", {31'd0, o_pc_enable}, 32'd0);
    tick();
    check_eq("trap_nxt", o_nxt_pc, VEC1);
    check_eq("trap_ack", {28'd0, o_irq_ack}, 32'b0010);
    check_eq("trap_en", {31'd0, o_pc_enable}, 32'd1);
    tick();
    check_eq("isr_pc", i_pc, VEC1);
    check_eq("isr_flag", {31'd0, o_in_isr}, 32'd1);
    check_eq("isr_ack", {28'd0, o_irq_ack}, 32'd0);
    i_irq = 4'b0001; #1;
    check_eq("nonest_flush", {31'd0, o_flush}, 32'd0);
    check_eq("nonest_en", {31'd0, o_pc_enable}, 32'd1);
    tick();
    i_irq = '0; i_mret = 1'b1; i_br_taken = 1'b1; i_br_target = 32'h900; #1;
    check_eq("mret_nxt", o_nxt_pc, 32'h1004);
    check_eq("mret_flush", {31'd0, o_flush}, 32'd1);
    tick();
    i_mret = 1'b0; i_br_taken = 1'b0; #1;
    check_eq("ret_pc", i_pc, 32'h1004);
    check_eq("ret_in_isr", {31'd0, o_in_isr}, 32'd0);
    i_mret = 1'b1; #1;
    check_eq("run_mret_nxt", o_nxt_pc, 32'h1008);
    check_eq("run_mret_flush", {31'd0, o_flush}, 32'd0);
    i_mret = 1'b0;

    // Branch and interrupt together; stall held two cycles in TRAP.
    i_br_taken = 1'b1; i_br_target = 32'h300; i_irq = 4'b0100; #1;
    check_eq("brirq_flush", {31'd0, o_flush}, 32'd1);
    tick();
    i_br_taken = 1'b0; i_irq = '0; #1;
    check_eq("brirq_mepc", o_mepc, 32'h300);
    check_eq("brirq_mcause", o_mcause, 32'h8000_0012);
    tick(); tick();
    i_stall = 1'b1; #1;
    check_eq("trapstall_ack0", {28'd0, o_irq_ack}, 32'd0);
    check_eq("trapstall_en0", {31'd0, o_pc_enable}, 32'd0);
    tick();
    check_eq("trapstall_ack1", {28'd0, o_irq_ack}, 32'd0);
    check_eq("trapstall_nxt", o_nxt_pc, VEC2);
    tick();
    i_stall = 1'b0; #1;
    check_eq("trapstall_ack2", {28'd0, o_irq_ack}, 32'b0100);
    tick();
    check_eq("trapstall_once", {28'd0, o_irq_ack}, 32'd0);
    check_eq("trapstall_isr", {31'd0, o_in_isr}, 32'd1);
    i_mret = 1'b1; tick(); i_mret = 1'b0; #1;
    check_eq("back_to_run", {31'd0, o_in_isr}, 32'd0);

    // Reset during DRAIN discards the trap.
    i_irq = 4'b0001; tick();
    i_irq = '0; i_rst = 1'b1; #1;
    check_eq("middrain_rst_nxt", o_nxt_pc, 32'h0);
    check_eq("middrain_rst_ack", {28'd0, o_irq_ack}, 32'd0);
    tick();
    i_rst = 1'b0; #1;
    check_eq("middrain_flush", {31'd0, o_flush}, 32'd0);
    check_eq("middrain_en", {31'd0, o_pc_enable}, 32'd1);
    check_eq("middrain_mepc", o_mepc, 32'h0);
    for (int c = 0; c < 4; c++) begin
      check_eq("middrain_noack", {28'd0, o_irq_ack}, 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
